msi_bus_arbiter: RTL and testbench

Snoopy-bus controller for the MSI coherence lab: shares one coherence bus between NUM_CACHES cache controllers (each an sm_cpu/sm_bus pair).
- Arbitrates requests round-robin.
- Broadcasts the winner's miss or invalidate to all other caches' snoop side.
- Collects snooper write-back responses and sequences the memory access.
- Pulses done to the winner.
- Sits between the per-cache state machines and the memory model/board LEDs.

---
 rtl/msi_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/msi_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_msi_bus_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/msi_pkg.sv
// Shared definitions for the MSI coherence lab: bus op codes, arbiter
// states (also shown on the board LEDs) and cache line state codes.
package msi_pkg;

  typedef enum logic [1:0] {
    OP_NONE   = 2'b00,
    OP_RDMISS = 2'b01,
    OP_WRMISS = 2'b10,
    OP_INV    = 2'b11
  } bus_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_SNOOP  = 3'd2,
    ST_WRBACK = 3'd3,
    ST_MEM    = 3'd4,
    ST_DONE   = 3'd5
  } arb_state_e;

  typedef enum logic [1:0] {
    LINE_I = 2'b00,
    LINE_S = 2'b01,
    LINE_M = 2'b10
  } msi_line_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping around at N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [$clog2(N)-1:0] winner_o,
  output logic                 any_req_o
);
  localparam int IW = $clog2(N);

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= N) ? s - N : s;
  endfunction

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    winner_o = ptr_i;
    for (int k = N - 1; k >= 0; k--) begin
      winner_o = req_i[wrap_idx(int'(ptr_i), k)] ? IW'(wrap_idx(int'(ptr_i), k)) : winner_o;
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/msi_bus_arbiter.sv
// Snoopy-bus controller: round-robin arbitration, snoop broadcast, write-back
// or memory sequencing, done pulse. Macro MSI_ARB_STATS_EN adds stat counters.
module msi_bus_arbiter
  import msi_pkg::*;
#(
  parameter int NUM_CACHES  = 4,
  parameter int MEM_LATENCY = 3
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [NUM_CACHES-1:0]         req,
  input  logic [2*NUM_CACHES-1:0]       req_op,
  input  logic [NUM_CACHES-1:0]         wb_resp,
  output logic [NUM_CACHES-1:0]         grant,
  output logic                          snoop_valid,
  output logic [1:0]                    snoop_op,
  output logic [$clog2(NUM_CACHES)-1:0] snoop_src,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic                          abort_mem,
  output logic [NUM_CACHES-1:0]         done,
  output logic                          op_error,
  output logic                          busy,
  output logic [2:0]                    arb_state
`ifdef MSI_ARB_STATS_EN
  ,
  output logic [15:0]                   stat_txn,
  output logic [15:0]                   stat_wb
`endif
);
  localparam int IW = $clog2(NUM_CACHES);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam logic [NUM_CACHES-1:0] ONE_HOT0 = {{(NUM_CACHES-1){1'b0}}, 1'b1};

  arb_state_e              state_q, state_d;
  logic [IW-1:0]           winner_q, winner_d, ptr_q, ptr_d, pick_s;
  logic [1:0]              op_q, op_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    any_req_s;
  logic [NUM_CACHES-1:0]   win_oh_d, wb_masked_s;
  logic [NUM_CACHES-1:0]   grant_q, done_q;
  logic                    snoop_valid_q, mem_read_q, mem_write_q, abort_q, op_error_q, busy_q;
  logic [1:0]              snoop_op_q;
  logic [IW-1:0]           snoop_src_q;
  logic [2:0]              arb_state_q;

  rr_arbiter #(.N(NUM_CACHES)) u_rr (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .winner_o  (pick_s),
    .any_req_o (any_req_s)
  );

  // grant_q is the winner's one-hot during SNOOP, so it doubles as the mask.
  assign wb_masked_s = wb_resp & ~grant_q;
  assign win_oh_d    = ONE_HOT0 << winner_d;

  // Next-state logic; req and req_op only matter in IDLE, wb_resp only in SNOOP.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          winner_d = pick_s;
          op_d     = req_op[{pick_s, 1'b0} +: 2];
          state_d  = ST_GRANT;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_GRANT: state_d = (op_q == OP_NONE) ? ST_DONE : ST_SNOOP;
      ST_SNOOP: begin
        if (op_q == OP_INV) begin
          state_d = ST_DONE;
        end else if (|wb_masked_s) begin
          state_d = ST_WRBACK;
          cnt_d   = CW'(MEM_LATENCY);
        end else begin
          state_d = ST_MEM;
          cnt_d   = CW'(MEM_LATENCY);
        end
      end
      ST_WRBACK, ST_MEM: begin
        if (cnt_q > CW'(1)) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ptr_d   = (winner_q == IW'(NUM_CACHES - 1)) ? {IW{1'b0}} : winner_q + IW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State plus outputs registered from the decoded next state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      winner_q      <= {IW{1'b0}};
      ptr_q         <= {IW{1'b0}};
      op_q          <= 2'b00;
      cnt_q         <= {CW{1'b0}};
      grant_q       <= {NUM_CACHES{1'b0}};
      done_q        <= {NUM_CACHES{1'b0}};
      snoop_valid_q <= 1'b0;
      snoop_op_q    <= 2'b00;
      snoop_src_q   <= {IW{1'b0}};
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      abort_q       <= 1'b0;
      op_error_q    <= 1'b0;
      busy_q        <= 1'b0;
      arb_state_q   <= 3'd0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      ptr_q         <= ptr_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      grant_q       <= (state_d != ST_IDLE) ? win_oh_d : {NUM_CACHES{1'b0}};
      done_q        <= (state_d == ST_DONE) ? win_oh_d : {NUM_CACHES{1'b0}};
      snoop_valid_q <= (state_d == ST_SNOOP);
      snoop_op_q    <= (state_d == ST_SNOOP) ? op_d : 2'b00;
      snoop_src_q   <= (state_d == ST_SNOOP) ? winner_d : {IW{1'b0}};
      mem_read_q    <= (state_d == ST_MEM);
      mem_write_q   <= (state_d == ST_WRBACK);
      abort_q       <= (state_d == ST_WRBACK) && (cnt_d == CW'(1));
      op_error_q    <= (state_d == ST_GRANT) && (op_d == OP_NONE);
      busy_q        <= (state_d != ST_IDLE);
      arb_state_q   <= state_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign snoop_valid = snoop_valid_q;
  assign snoop_op    = snoop_op_q;
  assign snoop_src   = snoop_src_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign abort_mem   = abort_q;
  assign op_error    = op_error_q;
  assign busy        = busy_q;
  assign arb_state   = arb_state_q;

`ifdef MSI_ARB_STATS_EN
  logic [15:0] stat_txn_q, stat_wb_q;

  // Saturating counters: completed transactions and write-back entries.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stat_txn_q <= 16'd0;
      stat_wb_q  <= 16'd0;
    end else begin
      if (state_q == ST_DONE && stat_txn_q != 16'hFFFF) begin
        stat_txn_q <= stat_txn_q + 16'd1;
      end
      if (state_q == ST_SNOOP && state_d == ST_WRBACK && stat_wb_q != 16'hFFFF) begin
        stat_wb_q <= stat_wb_q + 16'd1;
      end
    end
  end

  assign stat_txn = stat_txn_q;
  assign stat_wb  = stat_wb_q;
`endif

endmodule

// File: tb/tb_msi_bus_arbiter.sv
// Scoreboard bench for msi_bus_arbiter: per-round reference model pushes
// expected transactions, a negedge monitor pops and compares on each done.
module tb_msi_bus_arbiter;
  import msi_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 3;

  logic          clock = 1'b0;
  logic          resetn;
  logic [N-1:0]  req;
  logic [2*N-1:0] req_op;
  logic [N-1:0]  wb_resp;
  logic [N-1:0]  grant, done;
  logic          snoop_valid, mem_read, mem_write, abort_mem, op_error, busy;
  logic [1:0]    snoop_op, snoop_src;
  logic [2:0]    arb_state;
`ifdef MSI_ARB_STATS_EN
  logic [15:0]   stat_txn, stat_wb;
`endif

  msi_bus_arbiter #(.NUM_CACHES(N), .MEM_LATENCY(LAT)) dut (
    .clock(clock), .resetn(resetn), .req(req), .req_op(req_op), .wb_resp(wb_resp),
    .grant(grant), .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_src(snoop_src),
    .mem_read(mem_read), .mem_write(mem_write), .abort_mem(abort_mem), .done(done),
    .op_error(op_error), .busy(busy), .arb_state(arb_state)
`ifdef MSI_ARB_STATS_EN
    , .stat_txn(stat_txn), .stat_wb(stat_wb)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int       idx;
    logic [1:0] op;
    int       rd;
    int       wr;
    bit       err;
    bit       snoop;
    int       done_cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         mptr  = 0;
  int         exp_txn = 0;
  int         exp_wb  = 0;
  bit         mon_en  = 1'b0;
  logic [1:0] r_op   [N];
  logic [N-1:0] wb_tab [N];
  bit         r_drop [N];

  // Snoopers answer for whichever cache is being broadcast.
  assign wb_resp = snoop_valid ? wb_tab[snoop_src] : 4'b0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: accumulate everything seen during a transaction, judge it at done.
  bit         open = 1'b0;
  bit         gstable;
  logic [N-1:0] g;
  int         nsnp, nrd, nwr, nab, nerr, ab_pos;
  logic [1:0] sop, ssrc;
  exp_t       m_e;
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (!open && grant != 4'b0000) begin
          open = 1'b1; g = grant; gstable = 1'b1;
          nsnp = 0; nrd = 0; nwr = 0; nab = 0; nerr = 0; ab_pos = 0; sop = 2'b00; ssrc = 2'b00;
        end
        if (open) begin
          if (grant != g) gstable = 1'b0;
          if (snoop_valid) begin nsnp++; sop = snoop_op; ssrc = snoop_src; end
          if (mem_read) nrd++;
          if (mem_write) nwr++;
          if (abort_mem) begin nab++; ab_pos = mem_write ? nwr : -1; end
          if (op_error) nerr++;
          if (done != 4'b0000) begin
            check("exp_available", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
              m_e = exp_q.pop_front();
              check("done_owner", 64'(done), 64'(4'b0001 << m_e.idx));
              check("grant_owner", 64'(g), 64'(4'b0001 << m_e.idx));
              check("grant_held", 64'(gstable), 64'd1);
              check("done_cycle", 64'(cyc), 64'(m_e.done_cyc));
              check("snoop_count", 64'(nsnp), 64'(m_e.snoop));
              if (m_e.snoop) begin
                check("snoop_op", 64'(sop), 64'(m_e.op));
                check("snoop_src", 64'(ssrc), 64'(m_e.idx));
              end
              check("mem_read_cycles", 64'(nrd), 64'(m_e.rd));
              check("mem_write_cycles", 64'(nwr), 64'(m_e.wr));
              check("abort_count", 64'(nab), 64'(m_e.wr > 0));
              if (m_e.wr > 0) check("abort_on_last_wb", 64'(ab_pos), 64'(LAT));
              check("op_error_count", 64'(nerr), 64'(m_e.err));
              check("state_at_done", 64'(arb_state), 64'(ST_DONE));
              check("busy_at_done", 64'(busy), 64'd1);
            end
            open = 1'b0;
          end
        end else if (snoop_valid || mem_read || mem_write || abort_mem || op_error || done != 4'b0000) begin
          check("idle_outputs_quiet", 64'({snoop_valid, mem_read, mem_write, abort_mem, op_error, done}), 64'd0);
        end
      end
    end
  end

  // Predict a whole round from the arbitration rules, then drive and wait.
  task automatic run_round(input logic [N-1:0] mask);
    logic [N-1:0] pend, outstanding, masked_wb;
    int t, win, glat, guard;
    bit found;
    exp_t e;
    pend = mask;
    t = cyc;
    while (pend != 4'b0000) begin
      found = 1'b0; win = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (mptr + k) % N;
        if (!found && pend[j]) begin win = j; found = 1'b1; end
      end
      e.idx = win;
      e.op  = r_op[win];
      masked_wb = wb_tab[win] & ~(4'b0001 << win);
      e.err   = (e.op == 2'b00);
      e.snoop = !e.err;
      e.rd = 0; e.wr = 0;
      if (e.op == 2'b01 || e.op == 2'b10) begin
        if (masked_wb != 4'b0000) e.wr = LAT; else e.rd = LAT;
      end
      glat = e.err ? 1 : ((e.op == 2'b11) ? 2 : 2 + LAT);
      e.done_cyc = t + 1 + glat;
      exp_q.push_back(e);
      exp_txn++;
      if (e.wr > 0) exp_wb++;
      pend[win] = 1'b0;
      mptr = (win + 1) % N;
      t = e.done_cyc + 1;
    end
    for (int i = 0; i < N; i++) req_op[2*i +: 2] = r_op[i];
    req = mask;
    outstanding = mask;
    guard = 0;
    while (outstanding != 4'b0000 && guard < 400) begin
      @(negedge clock);
      guard++;
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          outstanding[i] = 1'b0;
          req[i] = 1'b0;
        end else if (grant[i] && r_drop[i]) begin
          req[i] = 1'b0;
          req_op[2*i +: 2] = 2'($urandom_range(0, 3));
        end
      end
    end
    if (outstanding != 4'b0000) check("round_timeout", 64'(outstanding), 64'd0);
    @(posedge clock); #1;
  endtask

  task automatic clear_tabs();
    for (int i = 0; i < N; i++) begin r_op[i] = 2'b01; wb_tab[i] = 4'b0000; r_drop[i] = 1'b0; end
  endtask

  initial begin
    int guard;
    resetn = 1'b0; req = 4'b0000; req_op = 8'h00;
    clear_tabs();
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;

    // Reset in the middle of a memory read.
    @(posedge clock); #1;
    req = 4'b0010; req_op = 8'b0000_0100;
    guard = 0;
    do begin @(negedge clock); guard++; end while (!mem_read && guard < 20);
    check("reached_mem", 64'(mem_read), 64'd1);
    resetn = 1'b0;
    #1;
    check("reset_outputs", 64'({grant, snoop_valid, snoop_op, snoop_src, mem_read, mem_write,
                                abort_mem, done, op_error, busy}), 64'd0);
    check("reset_state", 64'(arb_state), 64'(ST_IDLE));
    req = 4'b0000; req_op = 8'h00;
    @(posedge clock); #1 resetn = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_after_reset", 64'({arb_state, busy, grant, done}), 64'd0);
    @(posedge clock); #1;
    mptr = 0;
    mon_en = 1'b1;

    clear_tabs(); r_op[1] = 2'b01;                      run_round(4'b0010);
    clear_tabs(); r_op[0] = 2'b10; wb_tab[0] = 4'b0100; run_round(4'b0001);
    clear_tabs(); r_op[3] = 2'b11; wb_tab[3] = 4'b0001; run_round(4'b1000);
    clear_tabs();
    for (int i = 0; i < N; i++) wb_tab[i] = 4'b0001 << i;
    run_round(4'b1111);
    run_round(4'b1111);
    clear_tabs(); r_op[2] = 2'b00;                      run_round(4'b0100);
    clear_tabs(); r_op[1] = 2'b10; r_drop[1] = 1'b1;    run_round(4'b0010);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) begin
        r_op[i]   = 2'($urandom_range(0, 3));
        wb_tab[i] = 4'($urandom_range(0, 15));
        r_drop[i] = ($urandom_range(0, 3) == 0);
      end
      run_round(4'($urandom_range(1, 15)));
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end

    repeat (4) @(negedge clock);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
`ifdef MSI_ARB_STATS_EN
    check("stat_txn", 64'(stat_txn), 64'(exp_txn));
    check("stat_wb", 64'(stat_wb), 64'(exp_wb));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
